pri_encoder_iterative: RTL and testbench
========================================

# pri_encoder_iterative

Parametrised, iterative multi-hit priority encoder. It accepts a WIDTH-bit request vector over a valid/ready handshake and emits the index of every set bit, lowest index first, one index per output handshake. It is the sequential successor to the single-shot 16-to-4 priority encoder and is used wherever all active requesters must be serviced in order, not just the winner.

## Interface
- WIDTH, default 16: request vector width, minimum 2.
- IDX_W, default $clog2(WIDTH): index width. This is a localparam derived from WIDTH and is not overridable.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- enable, input, 1: high lets the block operate; low stalls it.
- in_valid, input, 1: in_vec is valid.
- in_ready, output, 1: the block can accept a new vector.
- in_vec, input, WIDTH: request vector.
- out_valid, output, 1: out_idx, out_last and out_none are valid.
- out_ready, input, 1: the downstream block accepts the current beat.
- out_idx, output, IDX_W: index of the lowest pending set bit.
- out_last, output, 1: this is the final beat for the current vector.
- out_none, output, 1: the loaded vector was all zero.
- busy, output, 1: a vector is loaded, i.e. state is SCAN.
- hit_cnt, output, IDX_W+1: number of set bits in the loaded vector. Present only with PRI_ENC_HIT_CNT_EN.

## Operation
- The state machine has two states, IDLE and SCAN. It holds a pending register of WIDTH bits.
- **Accept.** in_ready = enable && (state==IDLE || (out_valid && out_ready && out_last)).
  - On in_valid && in_ready, the block loads in_vec into pending and enters (or stays in) SCAN.
  - It sets none_q = (in_vec==0).
- **Emit in SCAN**, when enable is high:
  - out_valid = 1.
  - out_idx = index of the lowest set bit of pending.
  - out_last = pending has at most one set bit.
  - out_none = none_q.
- **Zero vector.** This produces exactly one beat with out_idx=0, out_none=1, out_last=1.
- **Out handshake** (out_valid && out_ready):
  - The block clears bit out_idx in pending.
  - If out_last is set, it returns to IDLE, unless a new vector is accepted in the same cycle.
- **enable low:**
  - in_ready=0 and out_valid=0.
  - All state is held. Scanning resumes at the same index when enable returns high.
- **Stability under backpressure.** While out_valid=1 && out_ready=0, out_idx, out_last and out_none must stay stable.
- **Outputs when out_valid=0:** out_idx=0, out_last=0, out_none=0.
- in_ready depends combinationally on out_ready and enable. There is no combinational path from in_vec to any output.
- **Reset.** Asserting rst_n at any time, including mid-scan, forces immediately:
  - state=IDLE, pending=0, none_q=0, hit_cnt=0.
  - out_valid=0, out_idx=0, out_last=0, out_none=0, busy=0, in_ready=0.
  - Any partially emitted vector is discarded.

## Timing
- **Latency.** A vector accepted at edge N gives its first beat with out_valid=1 in cycle N+1.
- **Throughput.** One index per cycle while out_ready=1. A vector with K set bits (K≥1) needs exactly K output beats. A zero vector needs 1 beat.
- **Back-to-back.** A new vector may be accepted in the same cycle as the previous vector's last beat handshake. This leaves zero bubble cycles between vectors.
- **After reset release.** in_ready rises in the first cycle with rst_n=1 and enable=1.

## Configuration
- The macro is PRI_ENC_HIT_CNT_EN.
- **Defined:** the hit_cnt port exists. It is registered on accept with the popcount of in_vec and holds that value until the next accept or reset. It does not decrement as beats are emitted.
- **Undefined:** the port and the popcount logic are absent. All other behaviour is identical.

## Structure
- Package pri_enc_pkg holds:
  - typedef enum logic {IDLE, SCAN} pri_enc_state_t.
  - a lowest-set-bit helper function.
  - a popcount function.
- Sub-module pri_encoder_lsb (parameter WIDTH) is a purely combinational find-first-set. Its outputs are idx[IDX_W], found and onehot[WIDTH]. The parent uses onehot to clear pending.

## Test plan
- **Multi-hit order.** WIDTH=16, in_vec=16'h8421, out_ready=1 → out_idx 0,5,10,15 in consecutive cycles; out_last only on 15; hit_cnt=4 if the macro is defined.
- **Zero vector.** in_vec=16'h0000 → one beat with out_none=1, out_last=1, out_idx=0; back to IDLE the following cycle.
- **Backpressure.** in_vec=16'h0003, out_ready low for 3 cycles → out_idx=0 held stable with out_last=0; then beats 0 and 1, with out_last on 1.
- **Back-to-back.** 16'h0004 then 16'h8000 presented during the last beat → both accepted with no gap; beats 2 (last) then 15 (last).
- **Enable stall.** in_vec=16'h0111, enable low after the first beat for 2 cycles → out_valid=0 and in_ready=0 during the stall; resumes at 4, then 8.
- **Reset mid-scan.** rst_n low after beat 0 of 16'hFFFF → all outputs 0 immediately; after release, in_ready=1 and no stale beats appear.

Source files
------------

// File: rtl/pri_enc_pkg.sv
// Shared types and helpers for the iterative priority encoder.
// MAX_W bounds the vector width the helper functions accept (WIDTH <= MAX_W).
package pri_enc_pkg;

   localparam int MAX_W = 256;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } pri_enc_state_t;

   // Index of the lowest set bit; 0 when the vector is all zero.
   function automatic int lsb_index(input logic [MAX_W-1:0] v);
      int idx;
      idx = 0;
      for (int i = MAX_W - 1; i >= 0; i--) begin
         if (v[i]) begin
            idx = i;
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   // Number of set bits in the vector.
   function automatic int popcount(input logic [MAX_W-1:0] v);
      int cnt;
      cnt = 0;
      for (int i = 0; i < MAX_W; i++) begin
         cnt = cnt + int'(v[i]);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/pri_encoder_lsb.sv
// Combinational find-first-set: index, presence flag and one-hot mask of
// the lowest set bit of vec.
module pri_encoder_lsb
   import pri_enc_pkg::*;
#(
   parameter  int WIDTH = 16,
   localparam int IDX_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] vec,
   output logic [IDX_W-1:0] idx,
   output logic             found,
   output logic [WIDTH-1:0] onehot
);

   // Two's-complement trick isolates the lowest set bit.
   assign onehot = vec & (~vec + {{(WIDTH-1){1'b0}}, 1'b1});
   assign found  = |vec;
   assign idx    = IDX_W'(lsb_index(MAX_W'(vec)));

endmodule

// File: rtl/pri_encoder_iterative.sv
// Iterative multi-hit priority encoder: accepts a request vector and emits
// the index of every set bit, lowest first, one per output handshake.
// Optional feature macro: PRI_ENC_HIT_CNT_EN adds the hit_cnt output
// (popcount of the accepted vector, held until the next accept).
module pri_encoder_iterative
   import pri_enc_pkg::*;
#(
   parameter  int WIDTH = 16,
   localparam int IDX_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_vec,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_last,
   output logic             out_none,
   output logic             busy
`ifdef PRI_ENC_HIT_CNT_EN
   ,
   output logic [IDX_W:0]   hit_cnt
`endif
);

   pri_enc_state_t   state_q, state_d;
   logic [WIDTH-1:0] pending_q, pending_d;
   logic             none_q, none_d;

   logic [IDX_W-1:0] lsb_idx_s;
   logic             lsb_found_s;
   logic [WIDTH-1:0] lsb_onehot_s;
   logic             at_most_one_s;
   logic             out_hs_s;
   logic             accept_s;

   pri_encoder_lsb #(.WIDTH(WIDTH)) u_lsb (
      .vec    (pending_q),
      .idx    (lsb_idx_s),
      .found  (lsb_found_s),
      .onehot (lsb_onehot_s)
   );

   assign busy = (state_q == SCAN);

   // Beat decode, handshakes and next-state selection.
   always_comb begin
      out_valid     = 1'b0;
      out_idx       = {IDX_W{1'b0}};
      out_last      = 1'b0;
      out_none      = 1'b0;
      in_ready      = 1'b0;
      out_hs_s      = 1'b0;
      accept_s      = 1'b0;
      state_d       = state_q;
      pending_d     = pending_q;
      none_d        = none_q;
      // Clearing the lowest bit leaves zero iff at most one bit was set.
      at_most_one_s = ((pending_q & (pending_q - {{(WIDTH-1){1'b0}}, 1'b1}))
                       == {WIDTH{1'b0}});

      if (enable && (state_q == SCAN)) begin
         out_valid = 1'b1;
         out_idx   = lsb_idx_s;
         out_last  = at_most_one_s;
         out_none  = none_q;
      end else begin
         out_valid = 1'b0;
      end

      out_hs_s = out_valid && out_ready;

      // rst_n gating keeps in_ready low while reset is held.
      if (rst_n && enable && ((state_q == IDLE) || (out_hs_s && out_last))) begin
         in_ready = 1'b1;
      end else begin
         in_ready = 1'b0;
      end

      accept_s = in_valid && in_ready;

      if (accept_s) begin
         // A new vector replaces whatever the final beat would have cleared.
         pending_d = in_vec;
         none_d    = (in_vec == {WIDTH{1'b0}});
         state_d   = SCAN;
      end else if (out_hs_s) begin
         if (lsb_found_s) begin
            pending_d = pending_q & ~lsb_onehot_s;
         end else begin
            pending_d = pending_q;
         end
         if (out_last) begin
            state_d = IDLE;
         end else begin
            state_d = state_q;
         end
      end else begin
         state_d = state_q;
      end
   end

   // State, pending vector and zero-vector flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pending_q <= {WIDTH{1'b0}};
         none_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         none_q    <= none_d;
      end
   end

`ifdef PRI_ENC_HIT_CNT_EN
   logic [IDX_W:0] hit_cnt_q, hit_cnt_d;

   // Popcount of the accepted vector; held until the next accept.
   always_comb begin
      hit_cnt_d = hit_cnt_q;
      if (accept_s) begin
         hit_cnt_d = (IDX_W+1)'(popcount(MAX_W'(in_vec)));
      end else begin
         hit_cnt_d = hit_cnt_q;
      end
   end

   // Hit-count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt_q <= {(IDX_W+1){1'b0}};
      end else begin
         hit_cnt_q <= hit_cnt_d;
      end
   end

   assign hit_cnt = hit_cnt_q;
`endif

endmodule

// File: tb/tb_pri_encoder_iterative.sv
// Self-checking bench for pri_encoder_iterative (WIDTH=16): directed
// scenarios plus randomized traffic against a beat-queue reference model.
module tb_pri_encoder_iterative;

   localparam int WIDTH = 16;
   localparam int IDX_W = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             enable = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_vec = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [IDX_W-1:0] out_idx;
   logic             out_last;
   logic             out_none;
   logic             busy;
`ifdef PRI_ENC_HIT_CNT_EN
   logic [IDX_W:0]   hit_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      int idx;
      bit last;
      bit none;
      int hits;
   } beat_t;

   pri_encoder_iterative #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vec    (in_vec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .out_none  (out_none),
      .busy      (busy)
`ifdef PRI_ENC_HIT_CNT_EN
      ,
      .hit_cnt   (hit_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] obs();
      return {in_ready, busy, out_valid, out_last, out_none, out_idx};
   endfunction

   function automatic logic [8:0] pk(input logic ir, input logic b, input logic v,
                                     input logic l, input logic n, input logic [3:0] idx);
      return {ir, b, v, l, n, idx};
   endfunction

   task automatic drive(input logic en, input logic iv, input logic [WIDTH-1:0] v,
                        input logic ordy);
      enable    = en;
      in_valid  = iv;
      in_vec    = v;
      out_ready = ordy;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b1, 1'b1, 16'hFFFF, 1'b1);
      @(negedge clk); #1;
      n_cmp++; if (obs() !== pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0)) begin
         n_err++; $display("FAIL reset_hold: got %h expected %h", obs(), pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
      end
`ifdef PRI_ENC_HIT_CNT_EN
      n_cmp++; if (hit_cnt !== 5'd0) begin
         n_err++; $display("FAIL reset_hit_cnt: got %0d expected 0", hit_cnt);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 1'b0, 16'h0000, 1'b1);
      #1;
      n_cmp++; if (obs() !== pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0)) begin
         n_err++; $display("FAIL reset_release: got %h expected %h", obs(), pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
      end
   endtask

   task automatic test_multi_hit();
      logic [3:0] exp_idx [4];
      exp_idx = '{4'd0, 4'd5, 4'd10, 4'd15};
      @(negedge clk);
      drive(1'b1, 1'b1, 16'h8421, 1'b1);
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL multi_accept: in_ready got %b expected 1", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         n_cmp++; if (obs() !== pk(k == 3, 1'b1, 1'b1, k == 3, 1'b0, exp_idx[k])) begin
            n_err++; $display("FAIL multi_beat[%0d]: got %h expected %h", k, obs(), pk(k == 3, 1'b1, 1'b1, k == 3, 1'b0, exp_idx[k]));
         end
`ifdef PRI_ENC_HIT_CNT_EN
         n_cmp++; if (hit_cnt !== 5'd4) begin
            n_err++; $display("FAIL multi_hit_cnt: got %0d expected 4", hit_cnt);
         end
`endif
         @(negedge clk);
      end
      #1;
      n_cmp++; if (obs() !== pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0)) begin
         n_err++; $display("FAIL multi_idle: got %h expected %h", obs(), pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
      end
   endtask

   task automatic test_zero();
      @(negedge clk);
      drive(1'b1, 1'b1, 16'h0000, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_cmp++; if (obs() !== pk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0)) begin
         n_err++; $display("FAIL zero_beat: got %h expected %h", obs(), pk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0));
      end
      @(negedge clk); #1;
      n_cmp++; if (obs() !== pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0)) begin
         n_err++; $display("FAIL zero_idle: got %h expected %h", obs(), pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
      end
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      drive(1'b1, 1'b1, 16'h0003, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_cmp++; if (obs() !== pk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0)) begin
            n_err++; $display("FAIL bp_hold[%0d]: got %h expected %h", k, obs(), pk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0));
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      n_cmp++; if (obs() !== pk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0)) begin
         n_err++; $display("FAIL bp_beat0: got %h expected %h", obs(), pk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0));
      end
      @(negedge clk); #1;
      n_cmp++; if (obs() !== pk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1)) begin
         n_err++; $display("FAIL bp_beat1: got %h expected %h", obs(), pk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1));
      end
      @(negedge clk); #1;
      n_cmp++; if (obs() !== pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0)) begin
         n_err++; $display("FAIL bp_idle: got %h expected %h", obs(), pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      drive(1'b1, 1'b1, 16'h0004, 1'b1);
      @(negedge clk);
      in_vec = 16'h8000;
      #1;
      n_cmp++; if (obs() !== pk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd2)) begin
         n_err++; $display("FAIL b2b_first: got %h expected %h", obs(), pk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd2));
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_cmp++; if (obs() !== pk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd15)) begin
         n_err++; $display("FAIL b2b_second: got %h expected %h", obs(), pk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd15));
      end
      @(negedge clk); #1;
      n_cmp++; if (obs() !== pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0)) begin
         n_err++; $display("FAIL b2b_idle: got %h expected %h", obs(), pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
      end
   endtask

   task automatic test_enable_stall();
      @(negedge clk);
      drive(1'b1, 1'b1, 16'h0111, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_cmp++; if (obs() !== pk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0)) begin
         n_err++; $display("FAIL stall_beat0: got %h expected %h", obs(), pk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0));
      end
      @(negedge clk);
      drive(1'b0, 1'b1, 16'hFFFF, 1'b1);
      for (int k = 0; k < 2; k++) begin
         #1;
         n_cmp++; if (obs() !== pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0)) begin
            n_err++; $display("FAIL stall_hold[%0d]: got %h expected %h", k, obs(), pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0));
         end
         @(negedge clk);
      end
      drive(1'b1, 1'b0, 16'h0000, 1'b1);
      #1;
      n_cmp++; if (obs() !== pk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd4)) begin
         n_err++; $display("FAIL stall_resume4: got %h expected %h", obs(), pk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd4));
      end
      @(negedge clk); #1;
      n_cmp++; if (obs() !== pk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd8)) begin
         n_err++; $display("FAIL stall_resume8: got %h expected %h", obs(), pk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd8));
      end
      @(negedge clk); #1;
      n_cmp++; if (obs() !== pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0)) begin
         n_err++; $display("FAIL stall_idle: got %h expected %h", obs(), pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
      end
   endtask

   task automatic test_reset_mid_scan();
      @(negedge clk);
      drive(1'b1, 1'b1, 16'hFFFF, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_cmp++; if (obs() !== pk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0)) begin
         n_err++; $display("FAIL rst_mid_beat0: got %h expected %h", obs(), pk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0));
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_cmp++; if (obs() !== pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0)) begin
         n_err++; $display("FAIL rst_mid_clear: got %h expected %h", obs(), pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
      end
`ifdef PRI_ENC_HIT_CNT_EN
      n_cmp++; if (hit_cnt !== 5'd0) begin
         n_err++; $display("FAIL rst_mid_hit_cnt: got %0d expected 0", hit_cnt);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_cmp++; if (obs() !== pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0)) begin
            n_err++; $display("FAIL rst_mid_no_stale[%0d]: got %h expected %h", k, obs(), pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
         end
         @(negedge clk);
      end
   endtask

   task automatic test_random();
      localparam int NV = 60;
      beat_t            q[$];
      logic [WIDTH-1:0] vecs [NV];
      int               vec_i;
      int               cyc;
      int               cnt;
      int               seen;
      bit               en, iv, ordy, exp_v, exp_ir;
      for (int n = 0; n < NV; n++) begin
         case ($urandom_range(0, 3))
            0:       vecs[n] = 16'h0000;
            1:       vecs[n] = 16'($urandom);
            default: vecs[n] = 16'($urandom) & 16'($urandom) & 16'($urandom);
         endcase
      end
      vec_i = 0;
      cyc = 0;
      @(negedge clk);
      while ((vec_i < NV || q.size() > 0) && cyc < 5000) begin
         en   = ($urandom_range(0, 99) < 85);
         iv   = (vec_i < NV) && ($urandom_range(0, 9) < 6);
         ordy = ($urandom_range(0, 9) < 7);
         drive(en, iv, (vec_i < NV) ? vecs[vec_i] : 16'h0000, ordy);
         #1;
         exp_v  = en && (q.size() > 0);
         exp_ir = en && ((q.size() == 0) || ((q.size() == 1) && ordy));
         n_cmp++; if ({out_valid, in_ready} !== {exp_v, exp_ir}) begin
            n_err++; $display("FAIL rand_hs cyc %0d: valid/ready got %b%b expected %b%b", cyc, out_valid, in_ready, exp_v, exp_ir);
         end
         if (exp_v) begin
            n_cmp++; if (out_idx !== 4'(q[0].idx) || out_last !== q[0].last || out_none !== q[0].none) begin
               n_err++; $display("FAIL rand_beat cyc %0d: idx/last/none got %0d/%b/%b expected %0d/%b/%b", cyc, out_idx, out_last, out_none, q[0].idx, q[0].last, q[0].none);
            end
`ifdef PRI_ENC_HIT_CNT_EN
            n_cmp++; if (hit_cnt !== 5'(q[0].hits)) begin
               n_err++; $display("FAIL rand_hit_cnt cyc %0d: got %0d expected %0d", cyc, hit_cnt, q[0].hits);
            end
`endif
            if (ordy) void'(q.pop_front());
         end else begin
            n_cmp++; if ({out_idx, out_last, out_none} !== 6'd0) begin
               n_err++; $display("FAIL rand_idle_outs cyc %0d: got %0d/%b/%b expected 0/0/0", cyc, out_idx, out_last, out_none);
            end
         end
         if (iv && exp_ir) begin
            cnt = 0;
            for (int b = 0; b < WIDTH; b++) cnt += int'(vecs[vec_i][b]);
            if (cnt == 0) begin
               q.push_back('{idx: 0, last: 1'b1, none: 1'b1, hits: 0});
            end else begin
               seen = 0;
               for (int b = 0; b < WIDTH; b++) begin
                  if (vecs[vec_i][b]) begin
                     seen++;
                     q.push_back('{idx: b, last: (seen == cnt), none: 1'b0, hits: cnt});
                  end
               end
            end
            vec_i++;
         end
         cyc++;
         @(negedge clk);
      end
      n_cmp++; if (vec_i != NV || q.size() != 0) begin
         n_err++; $display("FAIL rand_timeout: sent %0d of %0d, %0d beats outstanding", vec_i, NV, q.size());
      end
      drive(1'b1, 1'b0, 16'h0000, 1'b1);
   endtask

   initial begin
      test_reset();
      test_multi_hit();
      test_zero();
      test_backpressure();
      test_back_to_back();
      test_enable_stall();
      test_reset_mid_scan();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
